pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

- Sequences the 5-stage 16-bit pipeline (IF/ID/EX/MEM/WB) that the instruction decoder feeds.
- From decoded read enables and register fields in ID, plus EX/MEM status, it generates:
  - PC and pipeline-register stall and flush controls;
  - load-use bubbles, taken-branch/JR flushes and memory-wait freezes;
  - the halt drain sequence.
- Also keeps a sticky memory-timeout error and a stall performance counter.

## Interface
- DRAIN_CYCLES, 3: cycles after HLT leaves ID until `halted` asserts (EX, MEM, WB drain).
- MEM_TIMEOUT, 255: max consecutive memory-wait cycles before `mem_err`; range 1..65535.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  4 each  source register fields of the instruction in ID.
- id_re  in  2  decoder read enables: bit0 qualifies id_rs, bit1 qualifies id_rt.
- id_halt  in  1  HLT decoded in ID.
- ex_rd  in  4  destination of the instruction in EX.
- ex_memread  in  1  LW in EX.
- ex_br_taken  in  1  B/JR resolved taken in EX.
- mem_req  in  1  LW/SW in MEM.
- mem_ready  in  1  data memory done this cycle.
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the respective register.
- ifid_flush, idex_flush  out  1 each  load a bubble (NOP) into the register.
- halted  out  1  processor halted; sticky until reset.
- mem_err  out  1  memory timeout; sticky until reset.
- stall_cnt  out  16  saturating count of cycles with pc_stall=1.

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED.
  - `drain_cnt`: down-counter, width clog2(DRAIN_CYCLES+1).
  - `wait_cnt`: 16-bit memory-wait counter.
  - `ret_state`: 1 bit, RUN or DRAIN.
- Freeze condition: `frz = mem_req & ~mem_ready`, evaluated in RUN, MEM_WAIT and DRAIN.
  - When true, assert pc/ifid/idex/exmem stall.
  - Both flushes are forced 0.
  - drain_cnt holds.
- Load-use hazard `lu = ex_memread & (ex_rd != 0) & ((id_re[0] & id_rs == ex_rd) | (id_re[1] & id_rt == ex_rd))`.
  - r0 never hazards.
  - In RUN without frz: pc_stall=1, ifid_stall=1, idex_flush=1.
- Taken branch, in RUN without frz: ifid_flush=1, idex_flush=1, pc not stalled.
  - Overrides lu; the stalled instruction is squashed anyway.
- Priority, highest first: frz, ex_br_taken, lu, id_halt.
- Transitions:
  - RUN→MEM_WAIT on frz; ret_state=RUN.
  - RUN→DRAIN on id_halt & ~ex_br_taken & ~lu & ~frz.
    - Load drain_cnt=DRAIN_CYCLES.
    - That cycle: pc_stall=1; HLT advances into EX.
  - DRAIN: pc_stall=1 and ifid_flush=1 every non-frozen cycle.
    - drain_cnt decrements; goes to HALTED when drain_cnt==1 and ~frz.
    - On frz: DRAIN→MEM_WAIT with ret_state=DRAIN.
  - MEM_WAIT→ret_state when mem_ready.
  - HALTED: pc/ifid/idex/exmem stall all 1; terminal; only rst_n exits.
- wait_cnt:
  - Clears on entry to MEM_WAIT and increments each cycle there.
  - Reaching MEM_TIMEOUT sets mem_err; the freeze continues.
- stall_cnt increments on every cycle with pc_stall=1, including HALTED, and saturates at 16'hFFFF.

## Timing
- Stall and flush outputs are combinational from state plus current inputs; same-cycle effect on the pipeline registers.
- State, counters, halted and mem_err are registered and update on the rising clk edge.
- Reset (rst_n=0, immediate):
  - state=RUN, all counters 0, ret_state=RUN.
  - halted=0, mem_err=0, stall_cnt=0.
  - All stall/flush outputs are 0 while reset is held.
- Load-use costs exactly 1 bubble; the dependent instruction re-enters ID compare next cycle with ex_memread=0.
- Taken branch costs 2 bubbles, same cycle as resolution.
- halted rises DRAIN_CYCLES+1 edges after the id_halt acceptance edge, plus any frozen cycles.
- Reset mid-DRAIN or mid-MEM_WAIT abandons the sequence; no partial state survives.
- mem_ready in the same cycle as mem_req means no freeze, no MEM_WAIT.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - state enum (RUN, MEM_WAIT, DRAIN, HALTED);
  - R0 = 4'h0;
  - stall/flush vector bit indices, shared with the top-level pipeline.
- One sub-module `load_use_detect`, purely combinational (id_rs, id_rt, id_re, ex_rd, ex_memread → lu); reused by the forwarding unit.
- FSM, counters and output decode live in `pipeline_hazard_ctrl`.

## Test plan
- Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_re=2'b01.
  - Expect 1 cycle of pc_stall=ifid_stall=idex_flush=1, then all 0.
  - Repeat with ex_rd=0: expect no stall.
- Branch over load-use: ex_br_taken=1 plus the hazard above.
  - Expect ifid_flush=idex_flush=1, pc_stall=0, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1.
  - Expect all four stalls=1 for 4 cycles, MEM_WAIT→RUN, stall_cnt=4.
- Halt with wait: id_halt=1 in RUN, then mem_req stall of 2 cycles during DRAIN.
  - Expect halted=1 exactly DRAIN_CYCLES+1+2 edges after acceptance.
  - halted stays 1 and all stalls stay 1 thereafter.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0.
  - Expect mem_err=1 after the 4th MEM_WAIT cycle; the freeze persists.
  - Asserting rst_n=0 clears mem_err, halted, stall_cnt and the outputs immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller: FSM states,
// stall/flush vector layout and a saturating-increment helper.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_DRAIN    = 2'd2;
  localparam state_t ST_HALTED   = 2'd3;

  localparam logic [3:0] R0 = 4'h0;

  // Bit positions inside the stall/flush control vector
  localparam int CTL_PC_STALL    = 0;
  localparam int CTL_IFID_STALL  = 1;
  localparam int CTL_IDEX_STALL  = 2;
  localparam int CTL_EXMEM_STALL = 3;
  localparam int CTL_IFID_FLUSH  = 4;
  localparam int CTL_IDEX_FLUSH  = 5;
  localparam int CTL_W           = 6;

  localparam logic [CTL_W-1:0] CTL_FREEZE = (6'd1 << CTL_PC_STALL) | (6'd1 << CTL_IFID_STALL) |
                                            (6'd1 << CTL_IDEX_STALL) | (6'd1 << CTL_EXMEM_STALL);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between the instruction in ID and a load in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic [1:0] id_re,
  input  logic [3:0] ex_rd,
  input  logic       ex_memread,
  output logic       lu
);

  // r0 is hardwired, so a load targeting it never creates a dependency
  assign lu = ex_memread & (ex_rd != R0) &
              ((id_re[0] & (id_rs == ex_rd)) | (id_re[1] & (id_rt == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stall/flush decode, memory-wait freeze, halt drain,
// sticky memory-timeout error and stall performance counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic [1:0]  id_re,
  input  logic        id_halt,
  input  logic [3:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
  localparam logic [15:0]   TIMEOUT    = 16'(MEM_TIMEOUT);

  state_t           state, state_nxt, eff_state;
  logic             ret_drain, ret_drain_nxt;
  logic [DW-1:0]    drain_cnt, drain_cnt_nxt;
  logic [15:0]      wait_cnt, wait_cnt_nxt;
  logic             lu, frz, err_hit;
  logic [CTL_W-1:0] ctl;

  load_use_detect u_load_use_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_re      (id_re),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .lu         (lu)
  );

  assign frz = mem_req & ~mem_ready;

  // The cycle a wait completes behaves as the state it returns to, so it is not a lost cycle
  always_comb begin
    if (state == ST_MEM_WAIT && !frz) begin
      eff_state = ret_drain ? ST_DRAIN : ST_RUN;
    end else begin
      eff_state = state;
    end
  end

  always_comb begin
    ctl           = '0;
    state_nxt     = eff_state;
    ret_drain_nxt = ret_drain;
    drain_cnt_nxt = drain_cnt;
    wait_cnt_nxt  = wait_cnt;
    err_hit       = 1'b0;
    case (eff_state)
      ST_RUN: begin
        if (frz) begin
          ctl           = CTL_FREEZE;
          state_nxt     = ST_MEM_WAIT;
          ret_drain_nxt = 1'b0;
          wait_cnt_nxt  = 16'd0;
        end else if (ex_br_taken) begin
          ctl[CTL_IFID_FLUSH] = 1'b1;
          ctl[CTL_IDEX_FLUSH] = 1'b1;
        end else if (lu) begin
          ctl[CTL_PC_STALL]   = 1'b1;
          ctl[CTL_IFID_STALL] = 1'b1;
          ctl[CTL_IDEX_FLUSH] = 1'b1;
        end else if (id_halt) begin
          ctl[CTL_PC_STALL] = 1'b1;
          state_nxt         = ST_DRAIN;
          drain_cnt_nxt     = DRAIN_LOAD;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (frz) begin
          ctl           = CTL_FREEZE;
          state_nxt     = ST_MEM_WAIT;
          ret_drain_nxt = 1'b1;
          wait_cnt_nxt  = 16'd0;
        end else begin
          ctl[CTL_PC_STALL]   = 1'b1;
          ctl[CTL_IFID_FLUSH] = 1'b1;
          drain_cnt_nxt       = drain_cnt - DRAIN_ONE;
          state_nxt           = (drain_cnt == DRAIN_ONE) ? ST_HALTED : ST_DRAIN;
        end
      end
      ST_MEM_WAIT: begin
        ctl          = CTL_FREEZE;
        wait_cnt_nxt = sat_inc16(wait_cnt);
        err_hit      = (wait_cnt_nxt >= TIMEOUT);
      end
      ST_HALTED: begin
        ctl = CTL_FREEZE;
      end
      default: begin
        ctl       = '0;
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign pc_stall    = rst_n & ctl[CTL_PC_STALL];
  assign ifid_stall  = rst_n & ctl[CTL_IFID_STALL];
  assign idex_stall  = rst_n & ctl[CTL_IDEX_STALL];
  assign exmem_stall = rst_n & ctl[CTL_EXMEM_STALL];
  assign ifid_flush  = rst_n & ctl[CTL_IFID_FLUSH];
  assign idex_flush  = rst_n & ctl[CTL_IDEX_FLUSH];

  // FSM, counters and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      ret_drain <= 1'b0;
      drain_cnt <= '0;
      wait_cnt  <= 16'd0;
      halted    <= 1'b0;
      mem_err   <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      ret_drain <= ret_drain_nxt;
      drain_cnt <= drain_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (state == ST_HALTED) begin
        halted <= 1'b1;
      end
      if (err_hit) begin
        mem_err <= 1'b1;
      end
      if (pc_stall) begin
        stall_cnt <= sat_inc16(stall_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: decode table, directed multi-cycle
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 3;
  localparam int TMO   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  id_rs, id_rt, ex_rd;
  logic [1:0]  id_re;
  logic        id_halt, ex_memread, ex_br_taken, mem_req, mem_ready;
  logic        pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush;
  logic        halted, mem_err;
  logic [15:0] stall_cnt;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_re(id_re),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_stall(idex_stall), .exmem_stall(exmem_stall), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: progress counted in non-frozen cycles, freezes as run lengths
  int  m_drain_left;
  bit  m_terminal, m_halted, m_err;
  int  m_frz_run;
  int  m_stall_cnt;

  typedef struct packed {
    logic [3:0] rs, rt;
    logic [1:0] re;
    logic [3:0] rd;
    logic       mr, br, hlt, mq, mrdy;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] dut_ctl();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush};
  endfunction

  function automatic bit ref_lu();
    bit hit = 1'b0;
    if (ex_memread && ex_rd != 4'd0) begin
      if (id_re[0] && id_rs == ex_rd) hit = 1'b1;
      if (id_re[1] && id_rt == ex_rd) hit = 1'b1;
    end
    return hit;
  endfunction

  // Expected {pc, ifid, idex, exmem stalls, ifid, idex flushes}
  function automatic logic [5:0] exp_ctl();
    bit frz = mem_req && !mem_ready;
    if (!rst_n)                return 6'b000000;
    else if (m_terminal)       return 6'b111100;
    else if (frz)              return 6'b111100;
    else if (m_drain_left > 0) return 6'b100010;
    else if (ex_br_taken)      return 6'b000011;
    else if (ref_lu())         return 6'b110001;
    else if (id_halt)          return 6'b100000;
    else                       return 6'b000000;
  endfunction

  task automatic model_reset();
    m_drain_left = 0; m_terminal = 1'b0; m_halted = 1'b0;
    m_err = 1'b0; m_frz_run = 0; m_stall_cnt = 0;
  endtask

  task automatic model_edge();
    bit frz = mem_req && !mem_ready;
    logic [5:0] c = exp_ctl();
    bit new_halted = m_halted | m_terminal;
    if (c[5] && m_stall_cnt < 65535) m_stall_cnt++;
    if (!m_terminal) begin
      if (frz) begin
        m_frz_run++;
        if (m_frz_run > TMO) m_err = 1'b1;
      end else begin
        m_frz_run = 0;
        if (m_drain_left > 0) begin
          m_drain_left--;
          if (m_drain_left == 0) m_terminal = 1'b1;
        end else if (!ex_br_taken && !ref_lu() && id_halt) begin
          m_drain_left = DRAIN;
        end
      end
    end
    m_halted = new_halted;
  endtask

  task automatic idle_inputs();
    id_rs = 4'd0; id_rt = 4'd0; id_re = 2'b00; id_halt = 1'b0; ex_rd = 4'd0;
    ex_memread = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic lu_inputs();
    id_rs = 4'd3; id_rt = 4'd0; id_re = 2'b01; ex_rd = 4'd3; ex_memread = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the next rising edge
  task automatic step(input string tag);
    @(negedge clk);
    chk({tag, ".ctl"}, 16'(dut_ctl()), 16'(exp_ctl()));
    chk({tag, ".halted"}, 16'(halted), 16'(m_halted));
    chk({tag, ".mem_err"}, 16'(mem_err), 16'(m_err));
    chk({tag, ".stall_cnt"}, stall_cnt, 16'(m_stall_cnt));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input bit check);
    rst_n = 1'b0;
    #1;
    if (check) begin
      chk("rst.ctl", 16'(dut_ctl()), 16'd0);
      chk("rst.halted", 16'(halted), 16'd0);
      chk("rst.mem_err", 16'(mem_err), 16'd0);
      chk("rst.stall_cnt", stall_cnt, 16'd0);
    end
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    idle_inputs();
    //            rs     rt     re     rd     mr    br    hlt   mq    mrdy  exp
    tbl[0]  = '{4'd3, 4'd0, 2'b01, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110001};
    tbl[1]  = '{4'd0, 4'd0, 2'b11, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[2]  = '{4'd1, 4'd5, 2'b10, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110001};
    tbl[3]  = '{4'd1, 4'd5, 2'b01, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[4]  = '{4'd3, 4'd0, 2'b01, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[5]  = '{4'd3, 4'd0, 2'b01, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
    tbl[6]  = '{4'd3, 4'd0, 2'b01, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b111100};
    tbl[7]  = '{4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b100000};
    tbl[8]  = '{4'd3, 4'd0, 2'b01, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b110001};
    tbl[9]  = '{4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
    tbl[10] = '{4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000011};
    tbl[11] = '{4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b111100};

    do_reset(1'b1);

    for (int i = 0; i < 12; i++) begin
      do_reset(1'b0);
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_re = tbl[i].re; ex_rd = tbl[i].rd;
      ex_memread = tbl[i].mr; ex_br_taken = tbl[i].br; id_halt = tbl[i].hlt;
      mem_req = tbl[i].mq; mem_ready = tbl[i].mrdy;
      #1;
      chk($sformatf("tbl%0d", i), 16'(dut_ctl()), 16'(tbl[i].exp));
    end

    // Load-use: one bubble, then the dependent instruction proceeds
    do_reset(1'b0);
    lu_inputs();
    step("lu1");
    ex_memread = 1'b0;
    step("lu2");
    chk("lu.stall_cnt", stall_cnt, 16'd1);
    ex_rd = 4'd0; id_rs = 4'd0; ex_memread = 1'b1;
    step("lu_r0");
    chk("lu_r0.stall_cnt", stall_cnt, 16'd1);

    // Taken branch squashes the load-use stall
    do_reset(1'b0);
    lu_inputs();
    ex_br_taken = 1'b1;
    step("br");
    chk("br.stall_cnt", stall_cnt, 16'd0);

    // Four-cycle memory wait, then completion and a normal hazard
    do_reset(1'b0);
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) step("mw");
    mem_ready = 1'b1;
    step("mw_done");
    chk("mw.stall_cnt", stall_cnt, 16'd4);
    mem_req = 1'b0; mem_ready = 1'b0;
    lu_inputs();
    step("mw_run");
    chk("mw_run.stall_cnt", stall_cnt, 16'd5);

    // Halt with a 2-cycle freeze inside the drain
    do_reset(1'b0);
    id_halt = 1'b1;
    step("hlt_acc");
    id_halt = 1'b0;
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      mem_req   = (k >= 2 && k <= 4);
      mem_ready = (k == 4);
      step("hlt_drain");
      edges++;
      if (halted) break;
    end
    chk("hlt.edges", 16'(edges), 16'(DRAIN + 1 + 2));
    for (int k = 0; k < 6; k++) begin
      id_halt = 1'($urandom); ex_br_taken = 1'($urandom);
      mem_req = 1'($urandom); mem_ready = 1'($urandom);
      lu_inputs();
      step("hlt_hold");
      chk("hlt_hold.halted", 16'(halted), 16'd1);
      chk("hlt_hold.stalls", 16'(dut_ctl()), 16'(6'b111100));
    end

    // Memory timeout: sticky error, freeze persists, reset clears at once
    do_reset(1'b0);
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("tmo");
    chk("tmo.before", 16'(mem_err), 16'd0);
    step("tmo4");
    chk("tmo.after", 16'(mem_err), 16'd1);
    step("tmo_hold");
    chk("tmo_hold.stalls", 16'(dut_ctl()), 16'(6'b111100));
    lu_inputs(); id_halt = 1'b1;
    do_reset(1'b1);

    // Randomized traffic with occasional mid-sequence resets
    for (int seg = 1; seg <= 4; seg++) begin
      do_reset(1'b0);
      for (int c = 0; c < 250; c++) begin
        id_rs = 4'($urandom_range(0, 3)); id_rt = 4'($urandom_range(0, 3));
        id_re = 2'($urandom); ex_rd = 4'($urandom_range(0, 3));
        ex_memread = 1'($urandom);
        ex_br_taken = ($urandom_range(0, 7) == 0);
        id_halt = ($urandom_range(0, 39) == 0);
        mem_req = ($urandom_range(0, 2) == 0) || (seg == 4 && $urandom_range(0, 1) == 0);
        mem_ready = ($urandom_range(0, seg) == 0);
        if ($urandom_range(0, 149) == 0) do_reset(1'b1);
        else step($sformatf("rnd%0d", seg));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
